// File: rtl/prefix_tracker_if.sv
// Decoder-side bus of the x86 prefix tracker: byte stream in, held prefix state out.
interface prefix_tracker_if;
  logic       byte_valid;
  logic [7:0] byte_in;
  logic       next_instruction;
  logic       is_prefix;
  logic       seg_override_active;
  logic [1:0] seg_override_sel;
  logic       rep_active;
  logic       rep_z;
  logic       lock_active;
  logic [3:0] prefix_count;
  logic       prefix_overflow;

  modport master (
    output byte_valid, byte_in, next_instruction,
    input  is_prefix, seg_override_active, seg_override_sel, rep_active,
           rep_z, lock_active, prefix_count, prefix_overflow
  );

  modport slave (
    input  byte_valid, byte_in, next_instruction,
    output is_prefix, seg_override_active, seg_override_sel, rep_active,
           rep_z, lock_active, prefix_count, prefix_overflow
  );
endinterface

// File: rtl/prefix_tracker.sv
// Tracks x86 instruction prefixes (segment override, REP/REPNE, LOCK) ahead of the opcode
// and keeps the prefix byte count used to rewind IP on string-instruction restart.
module prefix_tracker #(
  parameter int unsigned MAX_PREFIXES = 15
) (
  input  logic          clk,
  input  logic          reset_n,
  prefix_tracker_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PREFIXES);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PREFIX = 2'd1;
  localparam logic [1:0] OPCODE = 2'd2;

  logic [1:0]       r_state;
  logic             r_seg_act;
  logic [1:0]       r_seg_sel;
  logic             r_rep_act;
  logic             r_rep_z;
  logic             r_lock;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  logic [1:0]       w_state_nx;
  logic             w_seg_act_nx;
  logic [1:0]       w_seg_sel_nx;
  logic             w_rep_act_nx;
  logic             w_rep_z_nx;
  logic             w_lock_nx;
  logic [CNT_W-1:0] w_count_nx;
  logic             w_ovf_nx;

  logic       w_pfx;
  logic       w_pfx_seg;
  logic [1:0] w_seg_code;
  logic       w_pfx_rep;
  logic       w_pfx_lock;
  logic [1:0] w_base_state;
  logic       w_accept;

  // Prefix byte decode
  always_comb begin
    w_pfx_seg  = 1'b0;
    w_seg_code = 2'd0;
    w_pfx_rep  = 1'b0;
    w_pfx_lock = 1'b0;
    case (bus.byte_in)
      8'h26: begin w_pfx_seg = 1'b1; w_seg_code = 2'd0; end
      8'h2E: begin w_pfx_seg = 1'b1; w_seg_code = 2'd1; end
      8'h36: begin w_pfx_seg = 1'b1; w_seg_code = 2'd2; end
      8'h3E: begin w_pfx_seg = 1'b1; w_seg_code = 2'd3; end
      8'hF0: w_pfx_lock = 1'b1;
      8'hF2, 8'hF3: w_pfx_rep = 1'b1;
      default: ;
    endcase
    w_pfx = w_pfx_seg | w_pfx_rep | w_pfx_lock;
  end

  // next_instruction clears first, so a same-cycle byte sees IDLE semantics
  assign w_base_state = bus.next_instruction ? IDLE : r_state;
  assign w_accept     = bus.byte_valid && (w_base_state != OPCODE);
  assign bus.is_prefix = w_accept && w_pfx;

  always_comb begin
    w_state_nx   = r_state;
    w_seg_act_nx = r_seg_act;
    w_seg_sel_nx = r_seg_sel;
    w_rep_act_nx = r_rep_act;
    w_rep_z_nx   = r_rep_z;
    w_lock_nx    = r_lock;
    w_count_nx   = r_count;
    w_ovf_nx     = r_ovf;

    if (bus.next_instruction) begin
      w_state_nx   = IDLE;
      w_seg_act_nx = 1'b0;
      w_seg_sel_nx = 2'd0;
      w_rep_act_nx = 1'b0;
      w_rep_z_nx   = 1'b0;
      w_lock_nx    = 1'b0;
      w_count_nx   = '0;
      w_ovf_nx     = 1'b0;
    end

    if (w_accept) begin
      if (w_pfx) begin
        w_state_nx = PREFIX;
        if (w_count_nx == CNT_MAX) begin
          w_ovf_nx = 1'b1;
        end else begin
          w_count_nx = w_count_nx + CNT_W'(1);
        end
        if (w_pfx_seg) begin
          w_seg_act_nx = 1'b1;
          w_seg_sel_nx = w_seg_code;
        end
        if (w_pfx_rep) begin
          w_rep_act_nx = 1'b1;
          w_rep_z_nx   = bus.byte_in[0];
        end
        if (w_pfx_lock) begin
          w_lock_nx = 1'b1;
        end
      end else begin
        w_state_nx = OPCODE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_seg_act <= 1'b0;
      r_seg_sel <= 2'd0;
      r_rep_act <= 1'b0;
      r_rep_z   <= 1'b0;
      r_lock    <= 1'b0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_seg_act <= w_seg_act_nx;
      r_seg_sel <= w_seg_sel_nx;
      r_rep_act <= w_rep_act_nx;
      r_rep_z   <= w_rep_z_nx;
      r_lock    <= w_lock_nx;
      r_count   <= w_count_nx;
      r_ovf     <= w_ovf_nx;
    end
  end

  assign bus.seg_override_active = r_seg_act;
  assign bus.seg_override_sel    = r_seg_sel;
  assign bus.rep_active          = r_rep_act;
  assign bus.rep_z               = r_rep_z;
  assign bus.lock_active         = r_lock;
  assign bus.prefix_count        = r_count;
  assign bus.prefix_overflow     = r_ovf;

endmodule
